// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: two-requester round-robin stream arbiter; define STREAM_ARB_PKT_LOCK_EN to hold the grant until the last beat of a packet
module stream_rr_arbiter #(
    parameter int DATA_WD = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [DATA_WD-1:0] a_data,
    input  logic               a_valid,
    input  logic               a_last,
    output logic               a_ready,
    input  logic [DATA_WD-1:0] b_data,
    input  logic               b_valid,
    input  logic               b_last,
    output logic               b_ready,
    output logic [DATA_WD-1:0] c_data,
    output logic               c_valid,
    output logic               c_last,
    input  logic               c_ready,
    output logic [1:0]         grant
);
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
    state_t state, state_nxt;
    logic last_owner, last_owner_nxt;
    logic a_sel, b_sel, fire, rel;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end
    assign a_sel = state == GRANT_A;
    assign b_sel = state == GRANT_B;
    assign c_data = a_sel ? a_data : b_sel ? b_data : '0;
    assign c_valid = (a_sel & a_valid) | (b_sel & b_valid);
    assign c_last = (a_sel & a_last) | (b_sel & b_last);
    assign a_ready = a_sel & c_ready;
    assign b_ready = b_sel & c_ready;
    assign grant = {b_sel, a_sel};
    assign fire = c_valid & c_ready;
`ifdef STREAM_ARB_PKT_LOCK_EN
    assign rel = fire & c_last;
`else
    assign rel = fire;
`endif
    always_comb begin
        state_nxt = state;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: state_nxt = (a_valid && (!b_valid || last_owner)) ? GRANT_A : b_valid ? GRANT_B : IDLE;
            GRANT_A: begin
                last_owner_nxt = rel ? 1'b0 : last_owner;
                state_nxt = !rel ? GRANT_A : b_valid ? GRANT_B : IDLE;
            end
            GRANT_B: begin
                last_owner_nxt = rel ? 1'b1 : last_owner;
                state_nxt = !rel ? GRANT_B : a_valid ? GRANT_A : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: queue-driven sources and a scoreboard of expected output beats
module tb_stream_rr_arbiter;
    localparam int DW = 4;
    logic clk = 1'b0;
    logic rstn;
    logic [DW-1:0] a_data, b_data, c_data;
    logic a_valid, a_last, a_ready, b_valid, b_last, b_ready, c_valid, c_last, c_ready;
    logic [1:0] grant;
    logic [DW:0] a_q[$], b_q[$], exp_q[$];
    logic a_en = 1'b0, b_en = 1'b0, rdy_nxt = 1'b1, fa = 1'b0, fb = 1'b0;
    int n_vec = 0, n_err = 0;
    int g[6], gap_g[2], gap_v[2];

    stream_rr_arbiter #(.DATA_WD(DW)) dut (
        .clk(clk), .rstn(rstn),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .c_data(c_data), .c_valid(c_valid), .c_last(c_last), .c_ready(c_ready),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic drive();
        a_valid = a_en && a_q.size() > 0;
        a_data = a_q.size() > 0 ? a_q[0][DW-1:0] : '0;
        a_last = a_q.size() > 0 ? a_q[0][DW] : 1'b0;
        b_valid = b_en && b_q.size() > 0;
        b_data = b_q.size() > 0 ? b_q[0][DW-1:0] : '0;
        b_last = b_q.size() > 0 ? b_q[0][DW] : 1'b0;
        c_ready = rdy_nxt;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (fa && a_q.size() > 0) void'(a_q.pop_front());
        if (fb && b_q.size() > 0) void'(b_q.pop_front());
        drive();
        @(negedge clk);
        fa = a_valid && a_ready;
        fb = b_valid && b_ready;
        if (c_valid && c_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", int'({c_last, c_data}), -1);
            else check("beat", int'({c_last, c_data}), int'(exp_q.pop_front()));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle();
        check("drain", exp_q.size(), 0);
        cycle();
        cycle();
        check("drain_idle", int'(grant), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        drive();
        cycle();
        cycle();
        check("rst_grant", int'(grant), 0);
        check("rst_valid", int'(c_valid), 0);
        check("rst_data", int'(c_data), 0);
        rstn = 1'b1;

        a_q = '{5'h01, 5'h02, 5'h13};
        b_q = '{5'h09, 5'h0a, 5'h1b};
`ifdef STREAM_ARB_PKT_LOCK_EN
        exp_q = '{5'h01, 5'h02, 5'h13, 5'h09, 5'h0a, 5'h1b};
        g = '{1, 1, 1, 2, 2, 2};
`else
        exp_q = '{5'h01, 5'h09, 5'h02, 5'h0a, 5'h13, 5'h1b};
        g = '{1, 2, 1, 2, 1, 2};
`endif
        a_en = 1'b1;
        b_en = 1'b1;
        cycle();
        check("first_idle_grant", int'(grant), 0);
        check("first_idle_valid", int'(c_valid), 0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_grant", int'(grant), g[i]);
            check("rr_valid", int'(c_valid), 1);
            check("other_ready", int'(g[i] == 1 ? b_ready : a_ready), 0);
        end
        cycle();
        check("rr_done_grant", int'(grant), 0);
        check("rr_done_exp", exp_q.size(), 0);

        a_q = '{5'h05, 5'h06, 5'h17};
        b_q = '{5'h1c};
`ifdef STREAM_ARB_PKT_LOCK_EN
        exp_q = '{5'h05, 5'h06, 5'h17, 5'h1c};
        gap_g = '{1, 1};
        gap_v = '{0, 0};
`else
        exp_q = '{5'h05, 5'h1c, 5'h06, 5'h17};
        gap_g = '{2, 0};
        gap_v = '{1, 0};
`endif
        cycle();
        check("gap_idle", int'(grant), 0);
        cycle();
        check("gap_pick_a", int'(grant), 1);
        a_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("gap_grant", int'(grant), gap_g[i]);
            check("gap_valid", int'(c_valid), gap_v[i]);
        end
        a_en = 1'b1;
        drain();

        a_en = 1'b0;
        b_q = '{5'h0d, 5'h1e};
        exp_q = '{5'h0d, 5'h1e};
        rdy_nxt = 1'b0;
        cycle();
        check("stall_idle", int'(c_valid), 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_grant", int'(grant), 2);
            check("stall_valid", int'(c_valid), 1);
            check("stall_data", int'(c_data), 'hd);
            check("stall_ready", int'(b_ready), 0);
        end
        rdy_nxt = 1'b1;
        drain();

        b_en = 1'b0;
        a_en = 1'b1;
        a_q = '{5'h01, 5'h02, 5'h03, 5'h14};
        exp_q = '{5'h01, 5'h02};
        for (int i = 0; i < 20 && !(c_valid && c_data == 2); i++) cycle();
        check("beat2_seen", int'(c_valid && c_data == 2), 1);
        rstn = 1'b0;
        a_q = '{5'h18};
        b_q = '{5'h1f};
        fa = 1'b0;
        b_en = 1'b1;
        exp_q = '{5'h18, 5'h1f};
        cycle();
        check("mid_rst_grant", int'(grant), 0);
        check("mid_rst_a_ready", int'(a_ready), 0);
        check("mid_rst_b_ready", int'(b_ready), 0);
        check("mid_rst_valid", int'(c_valid), 0);
        check("mid_rst_data", int'(c_data), 0);
        check("mid_rst_last", int'(c_last), 0);
        rstn = 1'b1;
        cycle();
        check("post_rst_grant", int'(grant), 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WD, default 4, payload width of every data port.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- clk  input  1  single clock; all state on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- a_data  input  DATA_WD  requester A payload.
- a_valid  input  1  requester A beat valid.
- a_last  input  1  requester A final beat of packet.
- a_ready  output  1  requester A beat accepted.
- b_data  input  DATA_WD  requester B payload.
- b_valid  input  1  requester B beat valid.
- b_last  input  1  requester B final beat of packet.
- b_ready  output  1  requester B beat accepted.
- c_data  output  DATA_WD  arbitrated payload.
- c_valid  output  1  arbitrated beat valid.
- c_last  output  1  arbitrated final beat.
- c_ready  input  1  downstream accepts beat.
- grant  output  2  one-hot owner: [0]=A, [1]=B, 00=none.
REQ-003 SHALL be clocked by one clock, clk, with reset rstn synchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, GRANT_A, GRANT_B, state registered, plus a 1-bit last_owner register (0=A, 1=B).
REQ-005 In IDLE, SHALL drive c_valid=0, a_ready=0, b_ready=0, grant=00, and SHALL hold c_data and c_last at 0.
REQ-006 In IDLE, SHALL arbitrate as follows: only a_valid -> GRANT_A; only b_valid -> GRANT_B; both -> the requester not equal to last_owner; neither -> stay IDLE. Request-to-first-transfer latency is 1 cycle.
REQ-007 In GRANT_X, SHALL pass X through combinationally: c_data=x_data, c_valid=x_valid, c_last=x_last, x_ready=c_ready. The other requester's ready SHALL be 0, and grant SHALL be one-hot for X.
REQ-008 A fire SHALL be defined as c_valid && c_ready. Zero-cycle passthrough; no buffering; no beat lost or duplicated.
REQ-009 In GRANT_X, a fire with x_last=1 SHALL set last_owner=X and then move to GRANT_other if other_valid=1 that cycle, otherwise to IDLE. The back-to-back switch SHALL incur no bubble.
REQ-010 In GRANT_X, a fire with x_last=0, or no fire, SHALL hold GRANT_X. x_valid deasserting mid-packet SHALL NOT release the grant.
REQ-011 A requester SHALL never be granted twice in a row while the other holds valid at its release point; this guarantees starvation-freedom.
REQ-012 c_valid SHALL never depend on c_ready, so there is no combinational ready-to-valid loop.

Reset
REQ-013 While rstn=0 at a clk edge, the next state SHALL be IDLE and last_owner SHALL be 1 (B), so A wins the first contention.
REQ-014 Reset mid-packet SHALL abandon the packet. Outputs SHALL follow REQ-005 from the first cycle after the reset edge.
REQ-015 Outputs SHALL equal the IDLE values whenever the state is IDLE, including after reset.

Configuration
REQ-016 The macro STREAM_ARB_PKT_LOCK_EN SHALL select the release rule.
- Defined: the grant is held until the last-beat fire, per REQ-009 and REQ-010.
- Undefined: every fire SHALL be treated as the release point regardless of x_last, giving per-beat round-robin. c_last is still passed through unchanged.

Verification
REQ-017 Reset, then a_valid=b_valid=1 in the same cycle, c_ready=1 -> grant=01 one cycle later, and A's packet is delivered before B's.
REQ-018 With lock on, A sends a 3-beat packet (a_last on beat 3) while b_valid is held high -> b_ready=0 for all 3 beats, grant=10 on the cycle after beat 3, with no idle cycle.
REQ-019 With lock on, a_valid drops for 2 cycles mid-packet while b_valid=1 -> grant stays 01 and c_valid=0 during the gap.
REQ-020 c_ready=0 for 4 cycles during GRANT_B with b_valid=1 -> c_data stable, b_ready=0, no state change, and no fire counted.
REQ-021 With lock off, both requesters continuously valid, 6 beats -> c_data order A,B,A,B,A,B.
REQ-022 rstn=0 asserted on beat 2 of a 4-beat A packet -> state IDLE, all readies 0, grant=00 the next cycle; after release, contention goes to A.
